seq_detector_2b: RTL and testbench
==================================

Name: seq_detector_2b

Overview:
- Downstream consumer of the 2-bit enabled register stage: samples its registered 2-bit symbol whenever the enable is high.
- Detects the ordered symbol sequence 01 -> 10 -> 11 and emits a one-cycle registered match pulse.
- Keeps a saturating count of matches for observation in lab benches.

Parameters:
- CNT_W, 4, width of match counter; saturates at 2^CNT_W-1.
- TIMEOUT, 4, consecutive idle (En=0) cycles tolerated mid-sequence; used only when SEQ_TIMEOUT_EN is defined. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- En  input  1  symbol valid; D is sampled only when En=1.
- D  input  2  symbol from upstream 2-bit register.
- clr  input  1  synchronous clear of count and sat only.
- match  output  1  one-cycle pulse, high the cycle after the 11 symbol completing the sequence is sampled.
- state  output  2  current FSM state encoding.
- count  output  CNT_W  number of matches, saturating.
- sat  output  1  high while count == 2^CNT_W-1.

Behaviour:
- All state changes occur on the rising clk edge.
- Reset: on an edge where reset=0, the block sets state=IDLE(00), match=0, count=0, sat=0, and clears the timeout counter. Reset overrides all other inputs, including mid-sequence.
- States:
  - IDLE=00: no prefix seen.
  - GOT_A=01: 01 seen.
  - GOT_B=10: 01,10 seen.
  - Encoding 11 is unused; if entered, the FSM goes to IDLE on the next edge.
- Transitions, evaluated only when En=1:
  - IDLE: D=01 -> GOT_A; else stay IDLE.
  - GOT_A: D=10 -> GOT_B; D=01 -> stay GOT_A; else -> IDLE.
  - GOT_B: D=11 -> IDLE with match; D=01 -> GOT_A; else -> IDLE.
- En=0: state holds and match<=0.
- match: registered. It is 1 for exactly the cycle following the edge that samples the completing 11 in GOT_B, and 0 otherwise. The minimum spacing between pulses is 3 cycles, so pulses never merge.
- count:
  - Increments by 1 on the match edge unless it is already at max; at max it holds.
  - sat is registered and equals (count == max).
  - No wrap-around.
- clr=1 (with reset=1): count<=0 and sat<=0. clr wins over a simultaneous match increment, but the match pulse is still generated. clr does not affect state.
- Latency: match and count update 1 cycle after the sampling edge of the final symbol.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - An internal counter of consecutive En=0 cycles runs while state is GOT_A or GOT_B.
  - When the counter reaches TIMEOUT, the next edge forces state=IDLE and clears the counter.
  - Any En=1 cycle clears the counter; reset clears it.
  - In IDLE the counter is held at 0.
- Not defined: no timeout logic is present; a partial sequence waits indefinitely across En=0 gaps.

Test Plan:
- Reset and recovery: reset=0 for 2 cycles with En=1, D=01 -> state=00, match=0, count=0. Then reset=1 with En=1, D=01,10,11 on consecutive cycles -> match=1 for 1 cycle after the 11 edge, count=1.
- Gapped sequence: En=1 with D=01, then En=0 for 2 cycles, then En=1 with D=10,11 -> match pulse, count=1. With SEQ_TIMEOUT_EN and TIMEOUT=2, the same stimulus gives no match and state=00 after the gap.
- Restart and abort paths: D stream 01,01,10,11 -> one match; D stream 01,10,01,10,11 -> one match; D stream 01,10,00,11 -> no match.
- Saturation: with CNT_W=2, 5 complete sequences -> count goes 1,2,3,3,3, and sat=1 from the third match onward; match still pulses 5 times.
- clr collision: clr=1 on the same edge as a completing 11 -> match=1, count=0, sat=0. clr on any other cycle -> count=0 and state is unchanged.
- Mid-sequence reset: with state=GOT_B, reset=0 for 1 edge, then D=11 -> state=00, no match.

Source files
------------

// File: rtl/seq_detector_2b.sv
// Detector for the ordered 2-bit symbol sequence 01 -> 10 -> 11, with a saturating match counter.
// Optional idle timeout on partial sequences is built when SEQ_TIMEOUT_EN is defined.
module seq_detector_2b #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic [1:0]       D,
  input  logic             clr,
  output logic             match,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GOT_A  = 2'b01,
    GOT_B  = 2'b10,
    UNUSED = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LP_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // TIMEOUT must fit the 4-bit idle counter and be non-zero.
  if ((TIMEOUT < 1) || (TIMEOUT > 15)) begin : g_bad_timeout
    $error("seq_detector_2b: TIMEOUT out of range 1..15");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_match;
  logic             w_match_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_sat;
  logic             w_to_force;

`ifdef SEQ_TIMEOUT_EN
  localparam logic [3:0] LP_TIMEOUT = 4'(TIMEOUT);

  logic [3:0] r_to_cnt;
  logic       w_in_prefix;

  assign w_in_prefix = (r_state == GOT_A) || (r_state == GOT_B);
  assign w_to_force  = w_in_prefix && (r_to_cnt == LP_TIMEOUT);

  // Idle-cycle counter: runs only on En=0 while a prefix is pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_to_cnt <= 4'd0;
    end else if (!w_in_prefix || w_to_force || En) begin
      r_to_cnt <= 4'd0;
    end else begin
      r_to_cnt <= r_to_cnt + 4'd1;
    end
  end
`else
  assign w_to_force = 1'b0;
`endif

  // Next-state and match decode; a timeout overrides the symbol on that edge.
  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = 1'b0;
    if (w_to_force) begin
      w_state_nxt = IDLE;
    end else if (r_state == UNUSED) begin
      w_state_nxt = IDLE;
    end else if (En) begin
      case (r_state)
        IDLE: begin
          if (D == 2'b01) w_state_nxt = GOT_A;
          else            w_state_nxt = IDLE;
        end
        GOT_A: begin
          if      (D == 2'b10) w_state_nxt = GOT_B;
          else if (D == 2'b01) w_state_nxt = GOT_A;
          else                 w_state_nxt = IDLE;
        end
        GOT_B: begin
          if (D == 2'b11) begin
            w_state_nxt = IDLE;
            w_match_nxt = 1'b1;
          end else if (D == 2'b01) begin
            w_state_nxt = GOT_A;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Counter update: clear beats a same-edge increment; holds at max.
  always_comb begin
    w_count_nxt = r_count;
    if (clr) begin
      w_count_nxt = {CNT_W{1'b0}};
    end else if (w_match_nxt && (r_count != LP_CNT_MAX)) begin
      w_count_nxt = r_count + LP_CNT_ONE;
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Registered state, match pulse, count and saturation flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_match <= 1'b0;
      r_count <= {CNT_W{1'b0}};
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_match <= w_match_nxt;
      r_count <= w_count_nxt;
      r_sat   <= (w_count_nxt == LP_CNT_MAX);
    end
  end

  assign match = r_match;
  assign state = r_state;
  assign count = r_count;
  assign sat   = r_sat;

endmodule

// File: tb/tb_seq_detector_2b.sv
// Table-driven bench for seq_detector_2b (CNT_W=2, TIMEOUT=2); gap expectations follow SEQ_TIMEOUT_EN.
module tb_seq_detector_2b;

  localparam int CNT_W = 2;

  logic             clk;
  logic             reset;
  logic             En;
  logic [1:0]       D;
  logic             clr;
  logic             match;
  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             sat;

  int n_checks;
  int n_fail;

  seq_detector_2b #(.CNT_W(CNT_W), .TIMEOUT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .En    (En),
    .D     (D),
    .clr   (clr),
    .match (match),
    .state (state),
    .count (count),
    .sat   (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [1:0] d;
    logic       clr;
    logic       m;
    logic [1:0] st;
    logic [1:0] cnt;
    logic       s;
  } vec_t;

  localparam int NV = 37;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic e, input logic [1:0] dd, input logic c,
                              input logic m, input logic [1:0] st, input logic [1:0] cn, input logic s);
    vec_t v;
    v.rst_n = r; v.en = e; v.d = dd; v.clr = c;
    v.m = m; v.st = st; v.cnt = cn; v.s = s;
    return v;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic e, input logic [1:0] dd, input logic c,
                      input logic m, input logic [1:0] st, input logic [1:0] cn, input logic s);
    reset = r; En = e; D = dd; clr = c;
    @(posedge clk);
    #1;
    chk({tag, ".match"}, {3'b000, match}, {3'b000, m});
    chk({tag, ".state"}, {2'b00, state}, {2'b00, st});
    chk({tag, ".count"}, {2'b00, count}, {2'b00, cn});
    chk({tag, ".sat"},   {3'b000, sat},   {3'b000, s});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0; En = 1'b0; D = 2'b00; clr = 1'b0;

    // reset, then a clean 01,10,11
    vecs[0]  = mk(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'd0, 1'b0);
    vecs[3]  = mk(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 2'd0, 1'b0);
    vecs[4]  = mk(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 2'd1, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'd1, 1'b0);
    // restart 01,01,10,11
    vecs[6]  = mk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'd1, 1'b0);
    vecs[7]  = mk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'd1, 1'b0);
    vecs[8]  = mk(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 2'd1, 1'b0);
    vecs[9]  = mk(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 2'd2, 1'b0);
    // restart 01,10,01,10,11 -> count saturates at 3
    vecs[10] = mk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'd2, 1'b0);
    vecs[11] = mk(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 2'd2, 1'b0);
    vecs[12] = mk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'd2, 1'b0);
    vecs[13] = mk(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 2'd2, 1'b0);
    vecs[14] = mk(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 2'd3, 1'b1);
    // abort 01,10,00,11
    vecs[15] = mk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'd3, 1'b1);
    vecs[16] = mk(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 2'd3, 1'b1);
    vecs[17] = mk(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'd3, 1'b1);
    vecs[18] = mk(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 2'd3, 1'b1);
    // matches 4 and 5 hold at max
    vecs[19] = mk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'd3, 1'b1);
    vecs[20] = mk(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 2'd3, 1'b1);
    vecs[21] = mk(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 2'd3, 1'b1);
    vecs[22] = mk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'd3, 1'b1);
    vecs[23] = mk(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 2'd3, 1'b1);
    vecs[24] = mk(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 2'd3, 1'b1);
    // clr mid-sequence leaves the FSM alone
    vecs[25] = mk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'd3, 1'b1);
    vecs[26] = mk(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 2'b10, 2'd0, 1'b0);
    vecs[27] = mk(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 2'd1, 1'b0);
    // clr colliding with the completing 11
    vecs[28] = mk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'd1, 1'b0);
    vecs[29] = mk(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 2'd1, 1'b0);
    vecs[30] = mk(1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 2'b00, 2'd0, 1'b0);
    vecs[31] = mk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0);
    // clr with En=0, and a held 11 while En=0 is ignored
    vecs[32] = mk(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'd0, 1'b0);
    vecs[33] = mk(1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 2'b01, 2'd0, 1'b0);
    vecs[34] = mk(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 2'd0, 1'b0);
    vecs[35] = mk(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 2'b10, 2'd0, 1'b0);
    vecs[36] = mk(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].en, vecs[i].d, vecs[i].clr,
           vecs[i].m, vecs[i].st, vecs[i].cnt, vecs[i].s);
    end

    // gapped sequence: 01, two idle cycles, 10, 11
    step("gap0", 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 2'd0, 1'b0);
    step("gap1", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 2'd0, 1'b0);
    step("gap2", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 2'd0, 1'b0);
`ifdef SEQ_TIMEOUT_EN
    step("gap3", 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0);
    step("gap4", 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0);
`else
    step("gap3", 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 2'd0, 1'b0);
    step("gap4", 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 2'd1, 1'b0);
`endif

    // reset while in GOT_B discards the prefix and the count
    step("mrst0", 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, count, sat);
    step("mrst1", 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, count, sat);
    step("mrst2", 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0);
    step("mrst3", 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
